// File: rtl/mux_arbiter.sv
// Four-source round-robin burst arbiter: one source owns the output until LAST,
// MAX_BEATS transfers, or a dropped request, then one IDLE cycle before the next grant.
module mux_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [3:0]       REQ,
    input  logic [3:0]       LAST,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [WIDTH-1:0] D3,
    input  logic             Y_READY,
    output logic [3:0]       GNT,
    output logic             S1,
    output logic             S0,
    output logic [WIDTH-1:0] Y,
    output logic             Y_VALID,
    output logic             dbg_state_o,
    output logic [1:0]       dbg_ptr_o,
    output logic [7:0]       dbg_beats_o
);

    // Handshake: a beat transfers on any cycle where Y_VALID and Y_READY are both high;
    // Y_VALID follows the owner's REQ and Y_READY low simply holds everything.

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] MAX_B = 8'(MAX_BEATS);

    state_t     state_q;
    logic [3:0] gnt_q;
    logic [1:0] sel_q;
    logic [1:0] ptr_q;
    logic [7:0] beats_q;

    logic       busy;
    logic       owner_req;
    logic       xfer;
    logic [7:0] beats_inc;
    logic       release_now;
    logic [1:0] pick_idx;
    logic       pick_found;
    logic [1:0] cand;
    logic [WIDTH-1:0] y_mux;

    assign busy        = (state_q == BUSY);
    assign owner_req   = REQ[sel_q];
    assign xfer        = busy && owner_req && Y_READY;
    assign beats_inc   = beats_q + 8'd1;
    assign release_now = busy && (!owner_req ||
                                  (xfer && (LAST[sel_q] || beats_inc == MAX_B)));

    // First requester scanning ptr, ptr+1, ... modulo 4.
    always_comb begin
        pick_idx   = 2'd0;
        pick_found = 1'b0;
        cand       = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!pick_found && REQ[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        y_mux = '0;
        case (sel_q)
            2'd0: y_mux = D0;
            2'd1: y_mux = D1;
            2'd2: y_mux = D2;
            2'd3: y_mux = D3;
            default: y_mux = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            beats_q <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_q <= BUSY;
                        gnt_q   <= 4'b0001 << pick_idx;
                        sel_q   <= pick_idx;
                        beats_q <= 8'd0;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        state_q <= IDLE;
                        gnt_q   <= 4'b0000;
                        beats_q <= 8'd0;
                        ptr_q   <= sel_q + 2'd1;
                    end else if (xfer) begin
                        beats_q <= beats_inc;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 4'b0000;
                end
            endcase
        end
    end

    assign GNT         = gnt_q;
    assign S1          = sel_q[1];
    assign S0          = sel_q[0];
    assign Y_VALID     = busy && owner_req;
    assign Y           = busy ? y_mux : '0;
    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;
    assign dbg_beats_o = beats_q;

endmodule
